// File: rtl/riscv_uart_periph_if.sv
// riscv_uart_periph_if
// Data-bus side of the UART peripheral: single-cycle read/write strobes
// from the core, with a registered one-cycle completion pulse and read data.
interface riscv_uart_periph_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_we;
    logic        bus_re;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    modport master (
        output bus_addr, bus_wdata, bus_wstrb, bus_we, bus_re,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_wstrb, bus_we, bus_re,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/riscv_uart_periph.sv
// riscv_uart_periph
// Memory-mapped 8N1 UART: TX FIFO feeding a serialiser, RX deserialiser with
// a single holding register, STATUS/CTRL registers and a level interrupt.
// Register map (offset from BASE_ADDR): 0x0 TXDATA, 0x4 RXDATA,
// 0x8 STATUS (bits 4-6 write-one-to-clear), 0xC CTRL.
// Optional macro UART_LOOPBACK_EN: CTRL bit2 routes the internal TX line
// into the RX synchroniser and holds the uart_tx pin high.
module riscv_uart_periph #(
    parameter logic [15:0] CLK_DIV       = 16'd868,
    parameter int          TX_FIFO_DEPTH = 8,
    parameter logic [31:0] BASE_ADDR     = 32'h1000_0000
) (
    input  logic                      clk,
    input  logic                      rst_n,
    riscv_uart_periph_if.slave        bus,
    output logic                      uart_tx,
    input  logic                      uart_rx,
    output logic                      irq
);

    localparam int             PTR_W    = $clog2(TX_FIFO_DEPTH);
    localparam logic [PTR_W:0] PTR_ONE  = 1;
    localparam logic [15:0]    BIT_LAST = CLK_DIV - 16'd1;
    localparam logic [15:0]    HALF_DIV = CLK_DIV >> 1;
    localparam logic [15:0]    HALF_LAST = HALF_DIV - 16'd1;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic       sel;
    logic       wr_en;
    logic       rd_en;
    logic [1:0] reg_idx;
    logic       txdata_wr;
    logic       status_wr;
    logic       ctrl_wr;
    logic       rx_read;
    logic       unused_bits;

    assign sel       = (bus.bus_addr[31:4] == BASE_ADDR[31:4]) && (bus.bus_we || bus.bus_re);
    assign wr_en     = sel && bus.bus_we;
    // A combined write+read is treated purely as a write.
    assign rd_en     = sel && bus.bus_re && !bus.bus_we;
    assign reg_idx   = bus.bus_addr[3:2];
    assign txdata_wr = wr_en && (reg_idx == 2'd0) && bus.bus_wstrb[0];
    assign status_wr = wr_en && (reg_idx == 2'd2) && bus.bus_wstrb[0];
    assign ctrl_wr   = wr_en && (reg_idx == 2'd3) && bus.bus_wstrb[0];
    assign rx_read   = rd_en && (reg_idx == 2'd1);

    assign unused_bits = ^{bus.bus_addr[1:0], bus.bus_wdata[31:8], bus.bus_wstrb[3:1]};

    // ------------------------------------------------------------------
    // TX FIFO (extra pointer bit distinguishes full from empty)
    // ------------------------------------------------------------------
    logic [7:0]       fifo_mem [TX_FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             tx_overflow_evt;
    logic             tx_pop;

    assign fifo_empty      = (wr_ptr == rd_ptr);
    assign fifo_full       = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                             (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    // Fullness is judged at the start of the cycle, so a same-cycle pop
    // does not rescue a write into a full FIFO.
    assign fifo_push       = txdata_wr && !fifo_full;
    assign tx_overflow_evt = txdata_wr && fifo_full;

    // Advance FIFO pointers on push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (tx_pop)    rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (fifo_push) fifo_mem[wr_ptr[PTR_W-1:0]] <= bus.bus_wdata[7:0];
    end

    // ------------------------------------------------------------------
    // TX serialiser
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    tx_state_t   tx_state, tx_state_nxt;
    logic [15:0] tx_cnt, tx_cnt_nxt;
    logic [7:0]  tx_shift, tx_shift_nxt;
    logic [2:0]  tx_bit, tx_bit_nxt;
    logic        tx_line, tx_line_nxt;
    logic        tx_busy;

    assign tx_busy = (tx_state != TX_IDLE);

    // TX state register; the line itself is registered so the pin never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_bit   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // TX next state: each bit lasts CLK_DIV clocks via a reloaded down-counter.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_shift_nxt = tx_shift;
        tx_bit_nxt   = tx_bit;
        tx_line_nxt  = tx_line;
        tx_pop       = 1'b0;
        case (tx_state)
            TX_IDLE: begin
                tx_line_nxt = 1'b1;
                if (!fifo_empty) begin
                    tx_pop       = 1'b1;
                    tx_shift_nxt = fifo_mem[rd_ptr[PTR_W-1:0]];
                    tx_cnt_nxt   = BIT_LAST;
                    tx_line_nxt  = 1'b0;
                    tx_state_nxt = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_nxt   = BIT_LAST;
                    tx_bit_nxt   = 3'd0;
                    tx_line_nxt  = tx_shift[0];
                    tx_state_nxt = TX_DATA;
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt == 16'd0) begin
                    tx_cnt_nxt = BIT_LAST;
                    if (tx_bit == 3'd7) begin
                        tx_line_nxt  = 1'b1;
                        tx_state_nxt = TX_STOP;
                    end else begin
                        tx_bit_nxt   = tx_bit + 3'd1;
                        tx_shift_nxt = {1'b0, tx_shift[7:1]};
                        tx_line_nxt  = tx_shift[1];
                    end
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt == 16'd0) begin
                    tx_line_nxt  = 1'b1;
                    tx_state_nxt = TX_IDLE;
                end else begin
                    tx_cnt_nxt = tx_cnt - 16'd1;
                end
            end
            default: begin
                tx_line_nxt  = 1'b1;
                tx_state_nxt = TX_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Loopback selection
    // ------------------------------------------------------------------
    logic ctrl_lb;
    logic rx_src;

`ifdef UART_LOOPBACK_EN
    // Loopback control bit, written alongside the other CTRL bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ctrl_lb <= 1'b0;
        else if (ctrl_wr) ctrl_lb <= bus.bus_wdata[2];
    end

    assign rx_src  = ctrl_lb ? tx_line : uart_rx;
    assign uart_tx = ctrl_lb ? 1'b1 : tx_line;
`else
    assign ctrl_lb = 1'b0;
    assign rx_src  = uart_rx;
    assign uart_tx = tx_line;
`endif

    // ------------------------------------------------------------------
    // RX deserialiser
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    logic        rx_meta;
    logic        rx_sync;
    rx_state_t   rx_state, rx_state_nxt;
    logic [15:0] rx_cnt, rx_cnt_nxt;
    logic [7:0]  rx_shift, rx_shift_nxt;
    logic [2:0]  rx_bit, rx_bit_nxt;
    logic        rx_deliver;
    logic        rx_frame_evt;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_src;
            rx_sync <= rx_meta;
        end
    end

    // RX state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_shift <= '0;
            rx_bit   <= '0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_shift <= rx_shift_nxt;
            rx_bit   <= rx_bit_nxt;
        end
    end

    // RX next state: confirm start at half a bit, then sample each bit centre.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_shift_nxt = rx_shift;
        rx_bit_nxt   = rx_bit;
        rx_deliver   = 1'b0;
        rx_frame_evt = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_cnt_nxt   = HALF_LAST;
                    rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (rx_cnt == 16'd0) begin
                    if (rx_sync) begin
                        rx_state_nxt = RX_IDLE;
                    end else begin
                        rx_cnt_nxt   = BIT_LAST;
                        rx_bit_nxt   = 3'd0;
                        rx_state_nxt = RX_DATA;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt == 16'd0) begin
                    rx_shift_nxt = {rx_sync, rx_shift[7:1]};
                    rx_cnt_nxt   = BIT_LAST;
                    if (rx_bit == 3'd7) begin
                        rx_state_nxt = RX_STOP;
                    end else begin
                        rx_bit_nxt = rx_bit + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == 16'd0) begin
                    rx_state_nxt = RX_IDLE;
                    if (rx_sync) rx_deliver   = 1'b1;
                    else         rx_frame_evt = 1'b1;
                end else begin
                    rx_cnt_nxt = rx_cnt - 16'd1;
                end
            end
            default: rx_state_nxt = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers: RX holding, sticky flags, control
    // ------------------------------------------------------------------
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_overrun;
    logic       tx_overflow;
    logic       frame_err;
    logic       rx_irq_en;
    logic       txe_irq_en;

    // Holding register, sticky flags and CTRL; a new event wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid    <= 1'b0;
            rx_byte     <= '0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
            frame_err   <= 1'b0;
            rx_irq_en   <= 1'b0;
            txe_irq_en  <= 1'b0;
        end else begin
            if (status_wr) begin
                if (bus.bus_wdata[4]) rx_overrun  <= 1'b0;
                if (bus.bus_wdata[5]) tx_overflow <= 1'b0;
                if (bus.bus_wdata[6]) frame_err   <= 1'b0;
            end
            if (ctrl_wr) begin
                rx_irq_en  <= bus.bus_wdata[0];
                txe_irq_en <= bus.bus_wdata[1];
            end
            if (tx_overflow_evt) tx_overflow <= 1'b1;
            if (rx_frame_evt)    frame_err   <= 1'b1;
            if (rx_deliver) begin
                if (!rx_valid || rx_read) begin
                    rx_byte  <= rx_shift;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_read) begin
                rx_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    logic [31:0] rd_value;

    // Select the register image for the addressed offset.
    always_comb begin
        rd_value = '0;
        case (reg_idx)
            2'd0: rd_value = '0;
            2'd1: rd_value = {rx_valid, 23'd0, rx_byte};
            2'd2: rd_value = {25'd0, frame_err, tx_overflow, rx_overrun,
                              tx_busy, rx_valid, fifo_empty, fifo_full};
            2'd3: rd_value = {29'd0, ctrl_lb, txe_irq_en, rx_irq_en};
            default: rd_value = '0;
        endcase
    end

    // One-cycle completion pulse; read data is zero outside a read completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_ready <= 1'b0;
            bus.bus_rdata <= '0;
        end else begin
            bus.bus_ready <= sel;
            bus.bus_rdata <= rd_en ? rd_value : 32'd0;
        end
    end

    // Registered level interrupt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= (rx_irq_en && rx_valid) ||
                           (txe_irq_en && fifo_empty && !tx_busy);
    end

endmodule
